// File: rtl/ppu_frame_writer.sv
// ppu_frame_writer: palettes, packs and buffers PPU pixels into frame RAM.
// Double buffering is enabled by defining PPU_FRAME_DOUBLE_BUF_EN.
module ppu_frame_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LINE_WORDS = 40,
    parameter int LINES      = 144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_en,
    input  logic [1:0]  ppu_mode,
    input  logic [7:0]  ly,
    input  logic [7:0]  bgp,
    input  logic [1:0]  px_in,
    input  logic        px_valid,
    output logic        fb_wr,
    output logic [13:0] fb_addr,
    output logic [7:0]  fb_data,
    input  logic        fb_ready,
    output logic        frame_done,
    output logic        overflow,
    output logic        display_bank
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_DRAW   = 2'd3;
    localparam logic [7:0] X_LIM = 8'(LINE_WORDS * 4);
    localparam logic [7:0] Y_LIM = 8'(LINES);

    typedef enum logic {
        S_RUN,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
    } word_t;

    state_t      state_q, state_d;
    logic [1:0]  mode_q;
    logic [7:0]  ly_q;
    logic [7:0]  x_q, x_d;
    logic [7:0]  pack_q, pack_d;
    logic [12:0] gaddr_q, gaddr_d;
    word_t       mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        frame_done_q;
    logic        overflow_q, overflow_d;
    logic        wr_bank;

    logic        enter_draw, leave_draw, vb_rise;
    logic        x_clr, flush;
    logic [7:0]  x_cur;
    logic [1:0]  shade;
    logic [2:0]  sh;
    logic        px_ok, px_drop, px_acc;
    logic [12:0] word_addr;
    logic [7:0]  pix_byte;
    logic        push_req, push, pop, word_drop;
    logic        full, empty, done;
    word_t       push_word, head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
                && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop   = !empty && fb_ready;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign enter_draw = (ppu_mode == MODE_DRAW) && (mode_q != MODE_DRAW);
    assign leave_draw = (mode_q == MODE_DRAW) && (ppu_mode != MODE_DRAW);
    assign vb_rise    = (ppu_mode == MODE_VBLANK) && (mode_q != MODE_VBLANK);

    // x restarts on DRAW entry or a new line, visible to this cycle's pixel
    assign x_clr = enter_draw || (ly != ly_q);
    assign x_cur = x_clr ? 8'd0 : x_q;
    assign flush = lcd_en && leave_draw && (x_q[1:0] != 2'd0);

    assign shade     = bgp[{px_in, 1'b0} +: 2];
    assign px_ok     = lcd_en && px_valid && !flush;
    assign px_drop   = px_ok && ((x_cur >= X_LIM) || (ly >= Y_LIM));
    assign px_acc    = px_ok && !px_drop;
    assign word_addr = 13'(ly) * 13'(LINE_WORDS) + 13'(x_cur[7:2]);
    assign sh        = {x_cur[1:0], 1'b0};
    assign pix_byte  = ((x_cur[1:0] == 2'd0) ? 8'h00 : pack_q)
                     | ({shade, 6'b0} >> sh);

    assign push_req  = flush || (px_acc && (x_cur[1:0] == 2'd3));
    assign push_word = flush ? {gaddr_q, pack_q} : {word_addr, pix_byte};
    assign push      = push_req && (!full || pop);
    assign word_drop = push_req && !push;

    always_comb begin
        x_d     = x_cur;
        pack_d  = pack_q;
        gaddr_d = gaddr_q;
        if (flush) begin
            pack_d = 8'h00;
        end else if (px_acc) begin
            x_d     = x_cur + 8'd1;
            pack_d  = pix_byte;
            gaddr_d = word_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        if (!lcd_en) begin
            state_d = S_RUN;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (vb_rise) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (empty && !push_req) begin
                        done    = 1'b1;
                        state_d = S_RUN;
                    end
                end
            endcase
        end
    end

    assign overflow_d = (done ? 1'b0 : overflow_q) | px_drop | word_drop;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= 2'd0;
            ly_q         <= 8'd0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            mode_q       <= ppu_mode;
            ly_q         <= ly;
            frame_done_q <= done;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !lcd_en) begin
            x_q      <= 8'd0;
            pack_q   <= 8'h00;
            gaddr_q  <= 13'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            x_q     <= x_d;
            pack_q  <= pack_d;
            gaddr_q <= gaddr_d;
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
    end

`ifdef PPU_FRAME_DOUBLE_BUF_EN
    logic bank_q;

    always_ff @(posedge clk) begin
        if (rst)       bank_q <= 1'b0;
        else if (done) bank_q <= ~bank_q;
    end

    assign display_bank = bank_q;
    assign wr_bank      = ~bank_q;
`else
    assign display_bank = 1'b0;
    assign wr_bank      = 1'b0;
`endif

    assign fb_wr      = !empty;
    assign fb_addr    = empty ? 14'd0 : {wr_bank, head.addr};
    assign fb_data    = empty ? 8'h00 : head.data;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ppu_frame_writer.sv
// Bench for ppu_frame_writer: queue-based reference model, directed
// scenarios with literal expectations, then randomized line traffic.
`timescale 1ns/1ps
module tb_ppu_frame_writer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lcd_en = 1'b0;
    logic [1:0]  ppu_mode = 2'd0;
    logic [7:0]  ly = 8'd0;
    logic [7:0]  bgp = 8'd0;
    logic [1:0]  px_in = 2'd0;
    logic        px_valid = 1'b0;
    logic        fb_ready = 1'b0;
    logic        fb_wr;
    logic [13:0] fb_addr;
    logic [7:0]  fb_data;
    logic        frame_done;
    logic        overflow;
    logic        display_bank;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ppu_frame_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_en       (lcd_en),
        .ppu_mode     (ppu_mode),
        .ly           (ly),
        .bgp          (bgp),
        .px_in        (px_in),
        .px_valid     (px_valid),
        .fb_wr        (fb_wr),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_ready     (fb_ready),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .display_bank (display_bank)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: pending words, current pixel group, frame status.
    typedef struct packed {
        logic [12:0] a;
        logic [7:0]  d;
    } word_t;

    word_t      mq[$];
    logic [1:0] mgrp[$];
    int         mx;
    logic [12:0] mgaddr;
    logic [1:0] mprev_mode;
    logic [7:0] mprev_ly;
    bit         mdrain, mfd, mov, mbank;

    function automatic logic mwb();
`ifdef PPU_FRAME_DOUBLE_BUF_EN
        return ~mbank;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] grp_byte();
        logic [7:0] b = 8'h00;
        foreach (mgrp[i]) b = b | (8'(mgrp[i]) << (6 - 2 * i));
        return b;
    endfunction

    task automatic model_step();
        bit was_empty, req, drp, done, fl;
        word_t w;
        if (rst) begin
            mq.delete(); mgrp.delete();
            mx = 0; mgaddr = '0;
            mprev_mode = 2'd0; mprev_ly = 8'd0;
            mdrain = 0; mfd = 0; mov = 0; mbank = 0;
            return;
        end
        mfd = 0;
        if (!lcd_en) begin
            mq.delete(); mgrp.delete(); mx = 0; mdrain = 0;
            mprev_mode = ppu_mode; mprev_ly = ly;
            return;
        end
        was_empty = (mq.size() == 0);
        if (!was_empty && fb_ready) void'(mq.pop_front());
        req = 0; drp = 0; w = '0;
        fl = (mprev_mode == 2'd3) && (ppu_mode != 2'd3) && (mgrp.size() > 0);
        if (fl) begin
            w = '{a: mgaddr, d: grp_byte()};
            mgrp.delete();
            req = 1;
        end
        if (((ppu_mode == 2'd3) && (mprev_mode != 2'd3)) || (ly != mprev_ly)) begin
            mx = 0;
            mgrp.delete();
        end
        if (!fl && px_valid) begin
            if (mx >= 160 || ly >= 144) begin
                drp = 1;
            end else begin
                mgrp.push_back(bgp[2*px_in +: 2]);
                mgaddr = 13'(int'(ly) * 40 + mx / 4);
                mx++;
                if (mgrp.size() == 4) begin
                    w = '{a: mgaddr, d: grp_byte()};
                    mgrp.delete();
                    req = 1;
                end
            end
        end
        if (req) begin
            if (mq.size() < DEPTH) mq.push_back(w);
            else drp = 1;
        end
        done = mdrain && was_empty && !req;
        if (done) begin
            mdrain = 0;
            mfd = 1;
`ifdef PPU_FRAME_DOUBLE_BUF_EN
            mbank = ~mbank;
`endif
        end else if (!mdrain && ppu_mode == 2'd1 && mprev_mode != 2'd1) begin
            mdrain = 1;
        end
        mov = (done ? 1'b0 : mov) | drp;
        mprev_mode = ppu_mode;
        mprev_ly = ly;
    endtask

    logic [21:0] wlog[$];
    logic [21:0] elog[$];
    bit armed = 0;
    int fd_count = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("fb_wr", fb_wr, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("fb_addr", fb_addr, {mwb(), mq[0].a});
                chk("fb_data", fb_data, mq[0].d);
            end
            chk("frame_done", frame_done, mfd);
            chk("overflow", overflow, mov);
            chk("display_bank", display_bank, mbank);
            if (fb_wr && fb_ready) wlog.push_back({fb_addr, fb_data});
            if (frame_done) fd_count++;
        end
        model_step();
        if (rst) armed = 1;
    end

    logic exp_wb;

    function automatic logic [21:0] mkw(int addr, logic [7:0] data);
        return {exp_wb, 13'(addr), data};
    endfunction

    task automatic chk_log(string name);
        chk({name, "_count"}, wlog.size(), elog.size());
        foreach (elog[i])
            chk({name, "_word"}, (i < wlog.size()) ? 32'(wlog[i]) : 32'hDEADBEEF, elog[i]);
        wlog.delete();
        elog.delete();
    endtask

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(int idx);
        px_in = 2'(idx);
        px_valid = 1'b1;
        cyc();
        px_valid = 1'b0;
    endtask

    initial begin
        int fd0;
`ifdef PPU_FRAME_DOUBLE_BUF_EN
        exp_wb = 1'b1;
`else
        exp_wb = 1'b0;
`endif
        cyc(2);
        chk("rst_fb_wr", fb_wr, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_display_bank", display_bank, 0);

        rst = 0; lcd_en = 1; bgp = 8'hE4; ly = 8'd0; ppu_mode = 2'd3; fb_ready = 1;
        wlog.delete();
        pix(0); pix(1); pix(2);
        chk("t1_no_early_wr", fb_wr, 0);
        pix(3);
        chk("t1_wr_latency", fb_wr, 1);
        chk("t1_addr", fb_addr, {exp_wb, 13'd0});
        chk("t1_data", fb_data, 8'h1B);
        cyc(3);
        elog.push_back(mkw(0, 8'h1B));
        chk_log("t1");

        bgp = 8'h1B; ly = 8'd2;
        repeat (8) pix(0);
        cyc(3);
        elog.push_back(mkw(80, 8'hFF));
        elog.push_back(mkw(81, 8'hFF));
        chk_log("t2");

        bgp = 8'hE4; ly = 8'd0; fb_ready = 0;
        for (int i = 0; i < 24; i++) pix(i % 4);
        chk("t3_held_wr", fb_wr, 1);
        chk("t3_held_addr", fb_addr, {exp_wb, 13'd0});
        chk("t3_held_data", fb_data, 8'h1B);
        chk("t3_overflow", overflow, 1);
        fb_ready = 1;
        cyc(8);
        for (int i = 0; i < 4; i++) elog.push_back(mkw(i, 8'h1B));
        chk_log("t3");

        ly = 8'd5;
        repeat (6) pix(3);
        ppu_mode = 2'd0;
        cyc(4);
        elog.push_back(mkw(200, 8'hFF));
        elog.push_back(mkw(201, 8'hF0));
        chk_log("t4");

        ppu_mode = 2'd3; ly = 8'd6; fb_ready = 0;
        repeat (8) pix(1);
        fd0 = fd_count;
        ppu_mode = 2'd1;
        cyc();
        ppu_mode = 2'd0;
        cyc(6);
        chk("t5_no_early_done", fd_count - fd0, 0);
        chk("t5_overflow_held", overflow, 1);
        fb_ready = 1;
        cyc(6);
        chk("t5_done_once", fd_count - fd0, 1);
        chk("t5_overflow_clr", overflow, 0);
`ifdef PPU_FRAME_DOUBLE_BUF_EN
        chk("t5_bank", display_bank, 1);
`else
        chk("t5_bank", display_bank, 0);
`endif
        elog.push_back(mkw(240, 8'h55));
        elog.push_back(mkw(241, 8'h55));
        chk_log("t5");
`ifdef PPU_FRAME_DOUBLE_BUF_EN
        exp_wb = 1'b0;
`endif

        ppu_mode = 2'd3; ly = 8'd7; fb_ready = 0;
        repeat (8) pix(2);
        chk("t6_pending", fb_wr, 1);
        lcd_en = 0;
        cyc();
        chk("t6_flushed", fb_wr, 0);
        cyc(2);
        lcd_en = 1;
        cyc(2);
        chk("t6_idle", fb_wr, 0);
        ly = 8'd8; fb_ready = 1;
        pix(0); pix(1); pix(2); pix(3);
        cyc(3);
        elog.push_back(mkw(320, 8'h1B));
        chk_log("t6");

        for (int line = 0; line < 40; line++) begin
            int ncyc;
            if ($urandom_range(0, 9) == 0) begin
                ppu_mode = 2'd1;
                repeat ($urandom_range(1, 3)) begin
                    fb_ready = ($urandom_range(0, 3) != 0);
                    cyc();
                end
            end
            ppu_mode = 2'd2;
            bgp = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ly = 8'($urandom_range(144, 153));
            else ly = 8'($urandom_range(0, 143));
            repeat ($urandom_range(1, 3)) begin
                fb_ready = ($urandom_range(0, 3) != 0);
                cyc();
            end
            ppu_mode = 2'd3;
            ncyc = $urandom_range(0, 220);
            for (int c = 0; c < ncyc; c++) begin
                px_valid = ($urandom_range(0, 3) != 0);
                px_in = 2'($urandom);
                fb_ready = ($urandom_range(0, 3) != 0);
                cyc();
            end
            px_valid = 0;
            ppu_mode = 2'd0;
            if ($urandom_range(0, 14) == 0) begin
                lcd_en = 0;
                cyc(2);
                lcd_en = 1;
            end
            repeat ($urandom_range(1, 6)) begin
                fb_ready = ($urandom_range(0, 3) != 0);
                cyc();
            end
        end

        ppu_mode = 2'd1;
        cyc();
        ppu_mode = 2'd0;
        fb_ready = 1;
        cyc(20);
        chk("end_drained", fb_wr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
